// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Arbitrates PC redirects (trap > EX branch > ID jump) against hazard stalls.
// Drives the PC register controls, runs the imem req/ack handshake and
// delivers fetched words, with their PC, to the IF/ID boundary. A one-entry
// skid buffer absorbs a word that returns while ID is stalled.
//
// Optional feature macro: FETCH_CTRL_TRAP_EN adds trap_req/trap_vec as the
// highest-priority redirect source. Without it, trap is treated as 0.
//
// Ports:
//   clk, nrst                  clock, synchronous active-low reset
//   pc_cur                     current PC register value (not used internally)
//   hz_stall                   ID hazard stall, holds IF/ID contents
//   ex_br_taken/ex_br_target   EX branch redirect
//   id_jump/id_jump_target     ID jump redirect (ignored while hz_stall)
//   trap_req/trap_vec          trap redirect (FETCH_CTRL_TRAP_EN only)
//   imem_req/imem_addr         fetch request and address
//   imem_ack/imem_rdata        fetch completion and returned word
//   pc_stall/pc_branch/pc_jump/pc_target  PC register controls
//   if_valid/if_instr/if_pc    registered IF/ID outputs
//   flush_ifid/flush_idex      pipeline flush pulses
`timescale 1ns/1ps
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] pc_cur,
  input  logic        hz_stall,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  input  logic        id_jump,
  input  logic [31:0] id_jump_target,
`ifdef FETCH_CTRL_TRAP_EN
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        pc_stall,
  output logic        pc_branch,
  output logic        pc_jump,
  output logic [31:0] pc_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush_ifid,
  output logic        flush_idex
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DISCARD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] tgt_q, tgt_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  logic        trap_hit;
  logic [31:0] trap_tgt;
  logic        redir, redir_br, redir_jmp;
  logic [31:0] redir_tgt;

  // The fetch tracks its own req_addr; pc_cur is accepted for interface
  // compatibility only.
  logic unused_pc_cur;
  assign unused_pc_cur = ^pc_cur;

`ifdef FETCH_CTRL_TRAP_EN
  assign trap_hit = trap_req;
  assign trap_tgt = trap_vec;
`else
  assign trap_hit = 1'b0;
  assign trap_tgt = '0;
`endif

  // Redirect arbitration: trap > branch > jump; jump yields to hz_stall.
  always_comb begin
    redir_br  = 1'b0;
    redir_jmp = 1'b0;
    redir_tgt = '0;
    if (trap_hit) begin
      redir_br  = 1'b1;
      redir_tgt = trap_tgt;
    end else if (ex_br_taken) begin
      redir_br  = 1'b1;
      redir_tgt = ex_br_target;
    end else if (id_jump && !hz_stall) begin
      redir_jmp = 1'b1;
      redir_tgt = id_jump_target;
    end
    redir = redir_br | redir_jmp;
  end

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= RESET_PC;
      tgt_q       <= '0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      tgt_q       <= tgt_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (redir || !buf_valid_q || !hz_stall)
          state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redir)
          state_d = imem_ack ? ST_REQ : ST_DISCARD;
        else if (imem_ack && hz_stall && if_valid_q)
          state_d = ST_IDLE;
      end
      ST_DISCARD: begin
        if (imem_ack)
          state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    req_addr_d  = req_addr_q;
    tgt_d       = tgt_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    if (redir) begin
      if_valid_d  = 1'b0;
      buf_valid_d = 1'b0;
      // While a request is still in flight the memory must keep seeing the
      // old address, so the new target waits in tgt_q until the ack.
      if (state_q != ST_IDLE && !imem_ack)
        tgt_d = redir_tgt;
      else
        req_addr_d = redir_tgt;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (buf_valid_q) begin
            if (!hz_stall) begin
              if_valid_d  = 1'b1;
              if_instr_d  = buf_instr_q;
              if_pc_d     = buf_pc_q;
              buf_valid_d = 1'b0;
            end
          end else if (!hz_stall) begin
            if_valid_d = 1'b0;
          end
        end
        ST_REQ: begin
          if (imem_ack) begin
            req_addr_d = req_addr_q + 32'd4;
            if (!hz_stall || !if_valid_q) begin
              if_valid_d = 1'b1;
              if_instr_d = imem_rdata;
              if_pc_d    = req_addr_q;
            end else begin
              buf_valid_d = 1'b1;
              buf_instr_d = imem_rdata;
              buf_pc_d    = req_addr_q;
            end
          end else if (!hz_stall) begin
            if_valid_d = 1'b0;
          end
        end
        ST_DISCARD: begin
          if (imem_ack)
            req_addr_d = tgt_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    imem_req   = (state_q != ST_IDLE);
    imem_addr  = req_addr_q;
    pc_stall   = 1'b1;
    if (redir || (state_q == ST_REQ && imem_ack))
      pc_stall = 1'b0;
    pc_branch  = redir_br;
    pc_jump    = redir_jmp;
    pc_target  = redir_tgt;
    flush_ifid = redir;
    flush_idex = redir_br;
    if_valid   = if_valid_q;
    if_instr   = if_instr_q;
    if_pc      = if_pc_q;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_fetch_ctrl;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] pc_cur;
  logic        hz_stall;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic        id_jump;
  logic [31:0] id_jump_target;
`ifdef FETCH_CTRL_TRAP_EN
  logic        trap_req;
  logic [31:0] trap_vec;
`endif
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        pc_stall, pc_branch, pc_jump;
  logic [31:0] pc_target;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        flush_ifid, flush_idex;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  // Memory model: ack after mem_wait extra cycles, data = address ^ KEY.
  int   mem_wait;
  int   cnt;
  logic ack_force;
  assign imem_ack   = ack_force | (imem_req && (cnt >= mem_wait));
  assign imem_rdata = imem_addr ^ KEY;

  always @(posedge clk) begin
    if (!nrst || !imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .nrst(nrst), .pc_cur(pc_cur), .hz_stall(hz_stall),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
`ifdef FETCH_CTRL_TRAP_EN
    .trap_req(trap_req), .trap_vec(trap_vec),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_stall(pc_stall), .pc_branch(pc_branch), .pc_jump(pc_jump),
    .pc_target(pc_target), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .flush_ifid(flush_ifid), .flush_idex(flush_idex)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = pc ^ KEY;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz_stall       = 1'b0;
    ex_br_taken    = 1'b0;
    ex_br_target   = '0;
    id_jump        = 1'b0;
    id_jump_target = '0;
    ack_force      = 1'b0;
`ifdef FETCH_CTRL_TRAP_EN
    trap_req       = 1'b0;
    trap_vec       = '0;
`endif
  endtask

  // Leaves the bench in the first cycle after nrst rises (state IDLE).
  task automatic reset_start(input int w);
    nrst = 1'b0;
    clear_inputs();
    mem_wait = w;
    step();
    step();
    nrst = 1'b1;
  endtask

  // Monitor: ID consumes the IF/ID word at the edge where if_valid && !hz_stall.
  always @(negedge clk) begin
    if (if_valid && !hz_stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h instr %h expected no delivery", if_pc, if_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc", if_pc, e.pc);
        chk("sb_instr", if_instr, e.instr);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pc_cur = '0;
    nrst = 1'b0;
    clear_inputs();
    mem_wait = 0;

    // Reset values
    step();
    step();
    #2;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc_stall", {31'd0, pc_stall}, 32'd1);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
    chk("rst_pc_ctl", {30'd0, pc_branch, pc_jump}, 32'd0);

    // Zero-wait streaming fetch
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    nrst = 1'b1;
    chk("first_cycle_no_req", {31'd0, imem_req}, 32'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      step(); #2;
      chk("stream_req", {31'd0, imem_req}, 32'd1);
      chk("stream_addr", imem_addr, 32'(i * 4));
      chk("stream_pc_stall", {31'd0, pc_stall}, 32'd0);
    end
    step();
    nrst = 1'b0;

    // Branch while a 3-cycle fetch to 0x8 is outstanding
    reset_start(0);
    push(32'h0); push(32'h4); push(32'h100);
    step(); step();
    step(); mem_wait = 2;
    step(); ex_br_taken = 1'b1; ex_br_target = 32'h100; #2;
    chk("br_pc_stall", {31'd0, pc_stall}, 32'd0);
    chk("br_pc_branch", {31'd0, pc_branch}, 32'd1);
    chk("br_pc_jump", {31'd0, pc_jump}, 32'd0);
    chk("br_pc_target", pc_target, 32'h100);
    chk("br_flush_ifid", {31'd0, flush_ifid}, 32'd1);
    chk("br_flush_idex", {31'd0, flush_idex}, 32'd1);
    step(); ex_br_taken = 1'b0; #2;
    chk("disc_req", {31'd0, imem_req}, 32'd1);
    chk("disc_addr", imem_addr, 32'h8);
    chk("disc_pc_stall", {31'd0, pc_stall}, 32'd1);
    chk("disc_flush_ifid", {31'd0, flush_ifid}, 32'd0);
    chk("disc_flush_idex", {31'd0, flush_idex}, 32'd0);
    chk("disc_if_valid", {31'd0, if_valid}, 32'd0);
    step(); #2;
    chk("refetch_addr", imem_addr, 32'h100);
    chk("refetch_if_valid", {31'd0, if_valid}, 32'd0);
    step();
    step(); #2;
    chk("wait_if_valid", {31'd0, if_valid}, 32'd0);
    step(); #2;
    chk("br_new_if_pc", if_pc, 32'h100);
    nrst = 1'b0;

    // hz_stall with a word returning: skid buffer
    reset_start(0);
    push(32'h0); push(32'h4); push(32'h8);
    step();
    step(); hz_stall = 1'b1; #2;
    chk("skid_pc_stall", {31'd0, pc_stall}, 32'd0);
    step(); #2;
    chk("skid_no_req", {31'd0, imem_req}, 32'd0);
    chk("skid_held_pc_stall", {31'd0, pc_stall}, 32'd1);
    chk("skid_held_if_pc", if_pc, 32'h0);
    step(); #2;
    chk("skid_no_req2", {31'd0, imem_req}, 32'd0);
    step(); hz_stall = 1'b0;
    step(); #2;
    chk("skid_resume_addr", imem_addr, 32'h8);
    chk("skid_buf_if_pc", if_pc, 32'h4);
    step();
    nrst = 1'b0;

    // Jump + branch same cycle; jump during hz_stall ignored
    reset_start(0);
    push(32'h300); push(32'h304);
    step();
    id_jump = 1'b1; id_jump_target = 32'h200;
    ex_br_taken = 1'b1; ex_br_target = 32'h300; #2;
    chk("jb_pc_target", pc_target, 32'h300);
    chk("jb_pc_branch", {31'd0, pc_branch}, 32'd1);
    chk("jb_pc_jump", {31'd0, pc_jump}, 32'd0);
    chk("jb_flush_idex", {31'd0, flush_idex}, 32'd1);
    step(); id_jump = 1'b0; ex_br_taken = 1'b0; #2;
    chk("jb_if_valid", {31'd0, if_valid}, 32'd0);
    chk("jb_addr", imem_addr, 32'h300);
    step(); hz_stall = 1'b1; id_jump = 1'b1; #2;
    chk("jstall_pc_jump", {31'd0, pc_jump}, 32'd0);
    chk("jstall_flush_ifid", {31'd0, flush_ifid}, 32'd0);
    chk("jstall_addr", imem_addr, 32'h304);
    step(); #2;
    chk("jstall_pc_jump2", {31'd0, pc_jump}, 32'd0);
    chk("jstall_no_req", {31'd0, imem_req}, 32'd0);
    step(); hz_stall = 1'b0; id_jump = 1'b0;
    step(); #2;
    chk("jstall_if_pc", if_pc, 32'h304);
    nrst = 1'b0;

`ifdef FETCH_CTRL_TRAP_EN
    // Trap beats branch and jump
    reset_start(0);
    push(32'h80);
    step();
    trap_req = 1'b1; trap_vec = 32'h80;
    ex_br_taken = 1'b1; ex_br_target = 32'h300;
    id_jump = 1'b1; id_jump_target = 32'h200; #2;
    chk("trap_pc_target", pc_target, 32'h80);
    chk("trap_pc_branch", {31'd0, pc_branch}, 32'd1);
    chk("trap_pc_jump", {31'd0, pc_jump}, 32'd0);
    step(); clear_inputs();
    step();
    nrst = 1'b0;
`endif

    // Address wrap, then reset in DISCARD with a late ack
    reset_start(0);
    push(32'hFFFF_FFF8); push(32'hFFFF_FFFC); push(32'h0);
    step(); id_jump = 1'b1; id_jump_target = 32'hFFFF_FFF8; #2;
    chk("jmp_pc_jump", {31'd0, pc_jump}, 32'd1);
    chk("jmp_pc_branch", {31'd0, pc_branch}, 32'd0);
    chk("jmp_flush_ifid", {31'd0, flush_ifid}, 32'd1);
    chk("jmp_flush_idex", {31'd0, flush_idex}, 32'd0);
    chk("jmp_pc_target", pc_target, 32'hFFFF_FFF8);
    step(); id_jump = 1'b0;
    step(); #2;
    chk("wrap_addr_fffc", imem_addr, 32'hFFFF_FFFC);
    step(); #2;
    chk("wrap_addr_0", imem_addr, 32'h0);
    step(); mem_wait = 3;
    step(); ex_br_taken = 1'b1; ex_br_target = 32'h40;
    step(); ex_br_taken = 1'b0; #2;
    chk("rd_disc_pc_stall", {31'd0, pc_stall}, 32'd1);
    chk("rd_disc_addr", imem_addr, 32'h4);
    nrst = 1'b0;
    step(); #2;
    chk("rd_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rd_pc_stall", {31'd0, pc_stall}, 32'd1);
    chk("rd_imem_addr", imem_addr, 32'h0);
    chk("rd_if_valid", {31'd0, if_valid}, 32'd0);
    push(32'h0);
    nrst = 1'b1; mem_wait = 0; ack_force = 1'b1;
    step(); ack_force = 1'b0; #2;
    chk("late_ack_addr", imem_addr, 32'h0);
    step();
    nrst = 1'b0;
    step();
    step();

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
